nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs an N-nibble (4*NIBBLES-bit) add or subtract by time-sharing one instance of the team's 4-bit structural ripple adder (full_adder_4bit_st), one nibble per clock, LSB nibble first, with a registered carry between nibbles.
- Sits between a requester using a start/busy/done handshake and the 4-bit adder datapath. It trades latency for area in wide-operand arithmetic.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; legal range 1..16; operand width W = 4*NIBBLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high while a request is being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  W  result; held stable from done until the next accepted start.
- cout  output  1  carry out of the MSB nibble (for sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow of the full W-bit operation.

Behaviour:
- Clock and reset: Single clock domain, clk. rst is asynchronous and active-high. Under rst: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, nibble index=0, carry register=0. Operand registers clear to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: If start=1 at edge T0, latch a into A_r. Latch b (or ~b when sub=1) into B_r. Set the carry register to sub (0 for add, 1 for subtract). Set idx=0 and go to RUN. busy rises after T0. Otherwise stay in IDLE.
- RUN: The adder is fed A_r[4*idx+:4], B_r[4*idx+:4] and the carry register.
  - At each edge, write the adder's sum into sum[4*idx+:4]. Write the adder's cout into the carry register. Increment idx.
  - The nibble written at edge T0+k+1 is nibble k.
  - After the edge that writes nibble NIBBLES-1 (edge T0+NIBBLES), go to DONE.
- sum register update: sum is not cleared at start. It is rewritten nibble by nibble during RUN, so sum is invalid while busy=1.
- DONE (exactly one cycle, between edges T0+NIBBLES and T0+NIBBLES+1):
  - done=1, busy=0.
  - cout shows the final carry.
  - ovf = (A_r[W-1] == B_r[W-1]) && (sum[W-1] != A_r[W-1]).
  - The next edge returns the FSM to IDLE.
  - start is ignored in DONE.
- Latency: Total latency from start to done is NIBBLES+1 edges. The minimum start-to-start spacing is NIBBLES+2 cycles.
- start while busy=1, or in DONE: Ignored. Operands and sub are not resampled, and the operation in flight is unaffected.
- cout and ovf timing: Both are updated only on entry to DONE and held until the next DONE or rst. They are not valid while busy=1.
- Wrap-around: Results are modulo 2^W. Overflow and borrow are reported only through cout and ovf; no exception behaviour.
- Reset mid-operation: rst asserted in RUN or DONE aborts the operation immediately and asynchronously, applying all reset values. No done pulse is produced. After rst is released, the first start is processed normally.
- NIBBLES=1: RUN lasts exactly one cycle. Behaviour equals one adder pass plus a DONE cycle.

Test Plan:
- Add, no carry: NIBBLES=4, start with sub=0, a=0x1234, b=0x4321. Required response: busy high for 4 cycles, done at edge T0+4, sum=0x5555, cout=0, ovf=0.
- Carry ripple across nibbles: a=0xFFFF, b=0x0001, add. Required response: sum=0x0000, cout=1, ovf=0. Negative overflow case: a=0x8000, b=0x8000. Required response: sum=0x0000, cout=1, ovf=1.
- Positive signed overflow: a=0x7FFF, b=0x0001, add. Required response: sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: sub=1, a=0x0005, b=0x0007. Required response: sum=0xFFFE, cout=0, ovf=0. Then sub=1, a=0x0007, b=0x0005. Required response: sum=0x0002, cout=1.
- Handshake robustness:
  - Pulse start with a different a and b at T0+2 and during DONE. Required response: both ignored, original result returned.
  - Hold start high continuously. Required response: back-to-back operations every 6 cycles.
- Reset mid-operation: assert rst at T0+2 asynchronously, away from a clock edge. Required response: busy, done, sum, cout and ovf go to 0 immediately, with no done pulse. After release, 0x00FF+0x0001 gives sum=0x0100.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// ============================================================================
// nibble_serial_adder_ctrl : W-bit add/subtract computed one nibble per clock
//                            through a single 4-bit ripple adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic [IDXW-1:0]   r_idx;

    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [3:0]        w_nsum;
    logic [4:0]        w_c;
    logic              w_last;

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
    assign w_last  = (r_idx == c_LAST);
    assign w_c[0]  = r_carry;

    // Shared 4-bit ripple datapath, one full adder per bit.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_fa
            assign w_nsum[i]  = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
            assign w_c[i + 1] = (w_a_nib[i] & w_b_nib[i]) |
                                (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_sum[{r_idx, 2'b00} +: 4] <= w_nsum;
                r_carry <= w_c[4];
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_cout <= w_c[4];
                    r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_nsum[3] != r_a[W-1]);
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ============================================================================
// tb_nibble_serial_adder_ctrl : scoreboard bench for the nibble-serial adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder_ctrl;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_done_cyc = -1;
    bit          b2b = 1'b0;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum",  {16'd0, sum}, {16'd0, e.s});
                check("cout", {31'd0, cout}, {31'd0, e.c});
                check("ovf",  {31'd0, ovf},  {31'd0, e.o});
                check("busy_in_done", {31'd0, busy}, 32'd0);
            end
            if (b2b && last_done_cyc >= 0)
                check("b2b_spacing", cyc - last_done_cyc, 32'd6);
            last_done_cyc = cyc;
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        e.s = es; e.c = ec; e.o = eo;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("done_latency", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int n;
        exp_t e;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {16'd0, sum},  32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Start held high: three back-to-back operations.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        e.s = 16'h3333; e.c = 1'b0; e.o = 1'b0;
        repeat (3) sb_q.push_back(e);
        last_done_cyc = -1;
        b2b = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        start = 1'b0;
        check("b2b_count", n, 32'd3);
        @(negedge clk);
        b2b = 1'b0;

        // Stray starts at T0+2 and during DONE must be ignored.
        a = 16'h0100; b = 16'h0200; sub = 1'b0; start = 1'b1;
        e.s = 16'h0300; e.c = 1'b0; e.o = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("hs_done", {31'd0, done}, 32'd1);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hs_not_accepted", {30'd0, busy, done}, 32'd0);

        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_sum",  {16'd0, sum},  32'd0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        check("mid_rst_ovf",  {31'd0, ovf},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
